// File: rtl/mem_wb_stage.sv
// mem_wb_stage: M-stage data-memory access (req/ready handshake with timeout)
// and the memory-to-writeback pipeline register.
// Optional macro MEM_MISALIGN_CHECK_EN: abort word accesses whose low address
// bits are non-zero instead of issuing them.
module mem_wb_stage #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwrite_m,
  input  logic [1:0]  resultsrc_m,
  input  logic        memwrite_m,
  input  logic [31:0] aluresult_m,
  input  logic [31:0] writedata_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] pcplus4_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_m,
  output logic        regwrite_w,
  output logic [4:0]  rd_w,
  output logic [31:0] result_w,
  output logic        bus_err_w,
  output logic        misaligned_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  state_t             state_q;
  logic [WAIT_W-1:0]  cnt_q;
  logic [31:0]        hold_q;
  logic               abort_q;
  logic               memop;
  logic               misaligned;
  logic [31:0]        result_d;
  logic               regwrite_q;
  logic [4:0]         rd_q;
  logic [31:0]        result_q;
  logic               bus_err_q;

  assign memop = memwrite_m | (resultsrc_m == 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_err_q;
  assign misaligned     = aluresult_m[1:0] != 2'b00;
  assign misaligned_err = mis_err_q;
`else
  assign misaligned     = 1'b0;
  assign misaligned_err = 1'b0;
`endif

  assign dmem_we    = memwrite_m;
  assign dmem_addr  = aluresult_m;
  assign dmem_wdata = writedata_m;

  // Request and stall are decoded from the current state; reset masks both.
  always_comb begin
    dmem_req = 1'b0;
    stall_m  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          dmem_req = memop & ~misaligned;
          stall_m  = memop;
        end
        ACCESS: begin
          dmem_req = 1'b1;
          stall_m  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Access FSM: wait counter, load-data hold register and abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      abort_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis_err_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_CHECK_EN
      mis_err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (memop) begin
            if (misaligned) begin
              abort_q <= 1'b1;
              state_q <= DONE;
`ifdef MEM_MISALIGN_CHECK_EN
              mis_err_q <= 1'b1;
`endif
            end else if (dmem_ready) begin
              hold_q  <= dmem_rdata;
              state_q <= DONE;
            end else begin
              cnt_q   <= WAIT_W'(1);
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            hold_q  <= dmem_rdata;
            state_q <= DONE;
          end else if (cnt_q == MAX_CNT) begin
            abort_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          abort_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Writeback source select; encoding 11 falls back to the ALU result.
  always_comb begin
    result_d = aluresult_m;
    unique case (resultsrc_m)
      2'b01:   result_d = hold_q;
      2'b10:   result_d = pcplus4_m;
      default: result_d = aluresult_m;
    endcase
  end

  // M/W boundary register: bubble while stalled, error-tagged after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      bus_err_q  <= 1'b0;
    end else if (stall_m) begin
      regwrite_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      rd_q <= rd_m;
      if (abort_q) begin
        regwrite_q <= 1'b0;
        bus_err_q  <= 1'b1;
        result_q   <= '0;
      end else begin
        regwrite_q <= regwrite_m;
        bus_err_q  <= 1'b0;
        result_q   <= result_d;
      end
    end
  end

  assign regwrite_w = regwrite_q;
  assign rd_w       = rd_q;
  assign result_w   = result_q;
  assign bus_err_w  = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. The driver issues
// instructions, plays the memory side and pushes the expected writeback;
// a monitor pops and compares on every cycle that commits a writeback.
module tb_mem_wb_stage;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_m;
  logic [1:0]  resultsrc_m;
  logic        memwrite_m;
  logic [31:0] aluresult_m;
  logic [31:0] writedata_m;
  logic [4:0]  rd_m;
  logic [31:0] pcplus4_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stall_m;
  logic        regwrite_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        bus_err_w;
  logic        misaligned_err;

  mem_wb_stage #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst),
    .regwrite_m(regwrite_m), .resultsrc_m(resultsrc_m), .memwrite_m(memwrite_m),
    .aluresult_m(aluresult_m), .writedata_m(writedata_m), .rd_m(rd_m),
    .pcplus4_m(pcplus4_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_m(stall_m),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .bus_err_w(bus_err_w), .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        be;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one instruction at a falling edge; waits = request cycles before
  // dmem_ready (waits > MAX_WAIT means memory never answers).
  task automatic issue(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4,
                       input logic [31:0] rdata, input int unsigned waits);
    logic        memop;
    logic        mis;
    logic        abort;
    int unsigned n;
    wb_t         e;
    @(negedge clk);
    regwrite_m = rw; resultsrc_m = rs; memwrite_m = mw;
    aluresult_m = alu; writedata_m = wd; rd_m = rd; pcplus4_m = pc4;
    dmem_ready = 1'b0; dmem_rdata = $urandom;
    memop = mw | (rs == 2'b01);
`ifdef MEM_MISALIGN_CHECK_EN
    mis = memop & (alu[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    abort = mis | (memop & (waits > MAX_WAIT));
    e.rw  = abort ? 1'b0 : rw;
    e.rd  = rd;
    e.be  = abort;
    e.res = abort ? 32'h0 : (rs == 2'b01) ? rdata : (rs == 2'b10) ? pc4 : alu;
    if (!memop) begin
      #1;
      check("alu_stall", {31'b0, stall_m}, 32'd0);
      check("alu_req", {31'b0, dmem_req}, 32'd0);
    end else if (mis) begin
      #1;
      check("mis_req", {31'b0, dmem_req}, 32'd0);
      check("mis_stall", {31'b0, stall_m}, 32'd1);
      @(negedge clk); #1;
      check("mis_pulse", {31'b0, misaligned_err}, 32'd1);
      check("mis_done_stall", {31'b0, stall_m}, 32'd0);
    end else begin
      n = (waits > MAX_WAIT) ? MAX_WAIT + 1 : waits + 1;
      for (int unsigned k = 0; k < n; k++) begin
        dmem_ready = (k == waits);
        dmem_rdata = (k == waits) ? rdata : $urandom;
        #1;
        check("req_high", {31'b0, dmem_req}, 32'd1);
        check("stall_high", {31'b0, stall_m}, 32'd1);
        check("dmem_we", {31'b0, dmem_we}, {31'b0, mw});
        check("dmem_addr", dmem_addr, alu);
        check("dmem_wdata", dmem_wdata, wd);
        @(negedge clk);
      end
      dmem_ready = 1'b0;
      #1;
      check("done_req", {31'b0, dmem_req}, 32'd0);
      check("done_stall", {31'b0, stall_m}, 32'd0);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: decide at the end of each cycle whether the edge commits a
  // writeback, then compare the boundary register just after the edge.
  initial begin : monitor
    logic        wb, in_rst;
    logic [4:0]  last_rd;
    logic [31:0] last_res;
    wb_t         e;
    last_rd = '0; last_res = '0;
    wait (mon_en);
    forever begin
      @(negedge clk); #3;
      wb = !stall_m && !rst;
      in_rst = rst;
      @(posedge clk); #1;
`ifndef MEM_MISALIGN_CHECK_EN
      check("mis_tied0", {31'b0, misaligned_err}, 32'd0);
`endif
      if (in_rst) begin
        last_rd = '0; last_res = '0;
        check("rst_regwrite", {31'b0, regwrite_w}, 32'd0);
        check("rst_bus_err", {31'b0, bus_err_w}, 32'd0);
        check("rst_rd", {27'b0, rd_w}, 32'd0);
        check("rst_result", result_w, 32'd0);
      end else if (wb) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL wb_unexpected: got writeback rd=%0d with empty scoreboard", rd_w);
        end else begin
          e = exp_q.pop_front();
          check("wb_regwrite", {31'b0, regwrite_w}, {31'b0, e.rw});
          check("wb_rd", {27'b0, rd_w}, {27'b0, e.rd});
          check("wb_result", result_w, e.res);
          check("wb_bus_err", {31'b0, bus_err_w}, {31'b0, e.be});
          last_rd = e.rd; last_res = e.res;
        end
      end else begin
        check("bubble_regwrite", {31'b0, regwrite_w}, 32'd0);
        check("bubble_bus_err", {31'b0, bus_err_w}, 32'd0);
        check("bubble_rd_hold", {27'b0, rd_w}, {27'b0, last_rd});
        check("bubble_res_hold", result_w, last_res);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [1:0]  kind;
    logic [31:0] addr;
    int unsigned w, r;
    rst = 1'b1;
    regwrite_m = 1'b1; resultsrc_m = 2'b01; memwrite_m = 1'b0;
    aluresult_m = 32'h100; writedata_m = '0; rd_m = 5'd3; pcplus4_m = '0;
    dmem_rdata = '0; dmem_ready = 1'b0;
    @(negedge clk); #1;
    check("rst_req_masked", {31'b0, dmem_req}, 32'd0);
    check("rst_stall_masked", {31'b0, stall_m}, 32'd0);
    @(posedge clk); #1;
    check("reset_regwrite_w", {31'b0, regwrite_w}, 32'd0);
    check("reset_rd_w", {27'b0, rd_w}, 32'd0);
    check("reset_result_w", result_w, 32'd0);
    check("reset_bus_err_w", {31'b0, bus_err_w}, 32'd0);
    check("reset_mis_err", {31'b0, misaligned_err}, 32'd0);
    resultsrc_m = 2'b00; rst = 1'b0; mon_en = 1'b1;

    // Directed cases.
    issue(1'b1, 2'b00, 1'b0, 32'hFFFF0001, 32'h0, 5'b10001, 32'h4, 32'h0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h00000100, 32'h0, 5'd5, 32'h8, 32'hCAFEBABE, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h00000200, 32'h0000FFFF, 5'd0, 32'hC, 32'h0, 3);
    issue(1'b1, 2'b01, 1'b0, 32'h00000300, 32'h0, 5'd7, 32'h10, 32'h12345678, MAX_WAIT + 1);
    issue(1'b1, 2'b10, 1'b0, 32'h00000010, 32'h0, 5'd1, 32'hF0F0F1F0, 32'h0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h00000400, 32'h0, 5'd8, 32'h14, 32'h11111111, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h00000404, 32'h0, 5'd9, 32'h18, 32'h22222222, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h00000408, 32'h0, 5'd10, 32'h1C, 32'h33333333, MAX_WAIT);
    issue(1'b1, 2'b11, 1'b0, 32'hA5A5A5A4, 32'h0, 5'd11, 32'h20, 32'h0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    issue(1'b1, 2'b01, 1'b0, 32'h00000102, 32'h0, 5'd12, 32'h24, 32'hDEADBEEF, 0);
`endif

    // Reset in the second wait cycle of a load: nothing may be written back.
    @(negedge clk);
    regwrite_m = 1'b1; resultsrc_m = 2'b01; memwrite_m = 1'b0;
    aluresult_m = 32'h00000500; rd_m = 5'd13; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_req", {31'b0, dmem_req}, 32'd0);
    check("midrst_stall", {31'b0, stall_m}, 32'd0);
    @(posedge clk); #1;
    resultsrc_m = 2'b00; regwrite_m = 1'b0; rst = 1'b0;
    // Back in IDLE: a zero-wait load must finish in two cycles.
    issue(1'b1, 2'b01, 1'b0, 32'h00000600, 32'h0, 5'd14, 32'h28, 32'h0BADF00D, 0);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      kind = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      w = (r == 9) ? MAX_WAIT + 1 : (r == 8) ? MAX_WAIT : $urandom_range(0, 3);
      unique case (kind)
        2'd0: issue(1'($urandom), 2'b00, 1'b0, $urandom, $urandom, 5'($urandom), $urandom, $urandom, 0);
        2'd1: issue(1'b1, 2'b01, 1'b0, addr, $urandom, 5'($urandom), $urandom, $urandom, w);
        2'd2: issue(1'b0, 2'($urandom_range(0, 1) * 2), 1'b1, addr, $urandom, 5'($urandom), $urandom, $urandom, w);
        default: issue(1'b1, 2'b10, 1'b0, $urandom, $urandom, 5'($urandom), $urandom, $urandom, 0);
      endcase
    end

    @(posedge clk); #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
